// File: rtl/codificador_bcd_secuencial_if.sv
// Conversion request in, BCD digits, status and display scan select out.
interface codificador_bcd_secuencial_if;
    logic       start;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic [3:0] cen;
    logic [3:0] j;
    logic [3:0] k;
    logic       ovf;
    logic       sel;

    modport master (output start, bin, input busy, done, cen, j, k, ovf, sel);
    modport slave  (input start, bin, output busy, done, cen, j, k, ovf, sel);
endinterface

// File: rtl/codificador_bcd_secuencial.sv
// Sequential shift-and-add-3 binary-to-BCD encoder, 9 cycles START to DONE; START ignored while busy.
// Also generates the free-running digit-select square wave for the multiplexed display.
module codificador_bcd_secuencial #(
    parameter int SCAN_DIV = 50000
) (
    input logic                          clk_i,
    input logic                          rst_i,
    codificador_bcd_secuencial_if.slave  bus
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sr_q,    sr_d;
    logic [11:0] acc_q,   acc_d;
    logic [2:0]  it_q,    it_d;
    logic [3:0]  cen_q,   cen_d;
    logic [3:0]  j_q,     j_d;
    logic [3:0]  k_q,     k_d;
    logic        ovf_q,   ovf_d;
    logic        done_q,  done_d;
    logic [CW-1:0] scan_q, scan_d;
    logic        sel_q,   sel_d;
    logic [11:0] adj;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        it_d    = it_q;
        cen_d   = cen_q;
        j_d     = j_q;
        k_d     = k_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        adj     = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = bus.bin;
                    acc_d   = 12'd0;
                    it_d    = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Correction happens on the pre-shift nibbles, then the whole pair shifts as one.
                {acc_d, sr_d} = {adj, sr_q} << 1;
                it_d          = it_q + 3'd1;
                if (it_q == 3'd7) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                cen_d   = acc_q[11:8];
                j_d     = acc_q[7:4];
                k_d     = acc_q[3:0];
                ovf_d   = |acc_q[11:8];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scan_d = scan_q + CW'(1);
        sel_d  = sel_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            sel_d  = ~sel_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sr_q    <= 8'd0;
            acc_q   <= 12'd0;
            it_q    <= 3'd0;
            cen_q   <= 4'd0;
            j_q     <= 4'd0;
            k_q     <= 4'd0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            scan_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            it_q    <= it_d;
            cen_q   <= cen_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.busy = (state_q == SHIFT) || (state_q == FIN);
    assign bus.done = done_q;
    assign bus.cen  = cen_q;
    assign bus.j    = j_q;
    assign bus.k    = k_q;
    assign bus.ovf  = ovf_q;
    assign bus.sel  = sel_q;

endmodule

// File: doc/codificador_bcd_secuencial.md
# codificador_bcd_secuencial

Sequential binary-to-BCD encoder (shift-and-add-3) that turns an 8-bit ALU result into decimal digits for the two-digit multiplexed seven-segment display. It produces the tens digit on J and the ones digit on K, the hundreds digit and an overflow flag, and the free-running digit-select clock SEL. All of these connect directly to the multiplexed BCD display driver. It is the producer side of that display interface: binary in, BCD digits plus scan select out.

## Interface
- SCAN_DIV, default 50000: clock cycles per SEL half-period; legal range ≥1.
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- START  input  1  conversion request, sampled only in IDLE.
- BIN  input  8  unsigned binary value to convert, sampled on the START edge.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when new digits are valid.
- CEN  output  4  hundreds digit (0–2).
- J  output  4  tens digit (0–9), to display digit 0.
- K  output  4  ones digit (0–9), to display digit 1.
- OVF  output  1  high when the value exceeds 99 (CEN ≠ 0); the display cannot show it fully.
- SEL  output  1  display digit select, square wave.

## Operation
- FSM states: IDLE, SHIFT, FIN.
- IDLE: if START=1, load the shift register with BIN, clear the 12-bit BCD accumulator, clear the iteration counter (3 bits), then go to SHIFT.
- SHIFT, one iteration per cycle:
  - Add 3 to each accumulator nibble whose value is ≥5.
  - Shift {accumulator, shift register} left by 1.
  - Increment the counter.
  - After the 8th iteration (counter was 7), go to FIN.
- FIN: copy the accumulator to CEN/J/K, set OVF = (accumulator[11:8] ≠ 0), pulse DONE, then return to IDLE.
- CEN/J/K/OVF hold their previous values throughout SHIFT. The display shows no intermediate digits.
- START while BUSY=1 is ignored and not queued. BIN changes after the START edge have no effect.
- START held high: a new conversion begins at the first IDLE edge after FIN (back-to-back).
- Arithmetic: nibble correction is 4-bit, applied before the shift. Any 8-bit input yields digits ≤9. Maximum input 255 gives CEN=2, J=5, K=5.
- Scan generator, independent of the FSM:
  - Counter counts 0..SCAN_DIV-1 and wraps to 0.
  - SEL toggles on each wrap.
  - SCAN_DIV=1 toggles SEL every cycle.
  - Counter width is ceil(log2(SCAN_DIV)), minimum 1 bit.

## Timing
- Reset values: BUSY=0, DONE=0, CEN=0, J=0, K=0, OVF=0, SEL=0. State=IDLE, scan counter=0.
- Reset has priority over every other event. Reset during SHIFT aborts the conversion: outputs return to 0, DONE is not asserted, and the next START converts normally.
- Edge e0: START=1 sampled in IDLE. Cycle after e0: BUSY=1.
- Edges e1..e8: the 8 iterations. e8 moves the FSM to FIN.
- Edge e9: digits and OVF update, DONE=1 for exactly one cycle, BUSY=0.
- Latency: START edge to DONE visible is 9 cycles. BUSY is high for 9 cycles (after e0 through e8).
- Earliest next START sample is e10, giving a throughput of 10 cycles per conversion.
- DONE and the output update occur on the same edge. Downstream may sample J/K while DONE=1.
- SEL: first toggle at edge SCAN_DIV after reset release; period is 2·SCAN_DIV cycles. Reset clears the scan counter and drives SEL low.

## Test plan
- BIN=0, START pulse → DONE 9 cycles later with CEN=0, J=0, K=0, OVF=0; BUSY high for exactly 9 cycles.
- BIN=99 → J=9, K=9, CEN=0, OVF=0. BIN=100 → CEN=1, J=0, K=0, OVF=1.
- BIN=255 → CEN=2, J=5, K=5, OVF=1. Exhaustive sweep 0..255 checked against a reference divide/mod model.
- START re-pulsed during BUSY with a different BIN → ignored; result matches the first BIN; only one DONE pulse.
- RST asserted mid-SHIFT (iteration 4) → all outputs 0 on the next cycle; no DONE pulse; a subsequent conversion of 42 gives J=4, K=2.
- SCAN_DIV=3 → SEL low for cycles 0–2 after reset, high for 3–5, toggling every 3 cycles. Toggle timing is unaffected by concurrent conversions.
